// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit ALU. Requests are buffered in a FIFO and executed one at a time.
// Each result is returned on a valid/ready port. Define ALU_OP_SEQUENCER_ERRCNT_EN to enable the saturating error counter.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [7:0]       req_data0_i,
    input  logic [7:0]       req_data1_i,
    input  logic [3:0]       req_ctrl_i,
    output logic [7:0]       alu_data0_o,
    output logic [7:0]       alu_data1_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [7:0]       alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [7:0]       rsp_result_o,
    output logic [3:0]       rsp_ctrl_o,
    output logic             rsp_err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic [7:0]       err_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_LAST = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic op_err(input logic [3:0] ctrl, input logic [7:0] d1);
        if (ctrl > OP_LAST)
            return 1'b1;
        if ((ctrl == OP_DIV || ctrl == OP_MOD) && d1 == 8'h00)
            return 1'b1;
        return 1'b0;
    endfunction

    // Error cases override whatever the ALU produced for that operand pair.
    function automatic logic [7:0] op_result(input logic [3:0] ctrl, input logic [7:0] d1,
                                             input logic [7:0] alu_res);
        if (ctrl > OP_LAST)
            return 8'h00;
        if ((ctrl == OP_DIV || ctrl == OP_MOD) && d1 == 8'h00)
            return 8'hFF;
        return alu_res;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [19:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             load_rsp;
    logic             rsp_ack;
    logic             fifo_empty;
    logic [19:0]      head;

    assign fifo_empty  = (count == '0);
    assign req_ready_o = (count != CNT_W'(DEPTH));
    assign push        = req_valid_i && req_ready_o;
    assign head        = mem[rd_ptr];
    assign count_o     = count;
    assign busy_o      = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= {req_ctrl_i, req_data1_i, req_data0_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A response handshake in RESP may issue the next op on the same edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_rsp   = 1'b0;
        rsp_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                load_rsp   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_ack = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_data0_o <= 8'h00;
            alu_data1_o <= 8'h00;
            alu_ctrl_o  <= 4'h0;
        end else if (pop) begin
            alu_data0_o <= head[7:0];
            alu_data1_o <= head[15:8];
            alu_ctrl_o  <= head[19:16];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= 8'h00;
            rsp_ctrl_o   <= 4'h0;
            rsp_err_o    <= 1'b0;
        end else if (load_rsp) begin
            rsp_valid_o  <= 1'b1;
            rsp_result_o <= op_result(alu_ctrl_o, alu_data1_o, alu_result_i);
            rsp_ctrl_o   <= alu_ctrl_o;
            rsp_err_o    <= op_err(alu_ctrl_o, alu_data1_o);
        end else if (rsp_ack) begin
            rsp_valid_o  <= 1'b0;
        end
    end

`ifdef ALU_OP_SEQUENCER_ERRCNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    logic [7:0] err_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_cnt <= 8'h00;
        else if (rsp_ack && rsp_err_o)
            err_cnt <= sat_inc8(err_cnt);
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model on the alu_* port.
// Covers latency, wrap/truncation, error codes, backpressure, simultaneous push/pop, and reset.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [3:0] req_ctrl;
    logic [7:0] alu_data0;
    logic [7:0] alu_data1;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_ctrl;
    logic       rsp_err;
    logic       busy;
    logic [2:0] count;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

`ifdef ALU_OP_SEQUENCER_ERRCNT_EN
    localparam int ERRCNT_EXP = 3;
`else
    localparam int ERRCNT_EXP = 0;
`endif

    alu_op_sequencer #(.DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data0_i (req_data0),
        .req_data1_i (req_data1),
        .req_ctrl_i  (req_ctrl),
        .alu_data0_o (alu_data0),
        .alu_data1_o (alu_data1),
        .alu_ctrl_o  (alu_ctrl),
        .alu_result_i(alu_result),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_result_o(rsp_result),
        .rsp_ctrl_o  (rsp_ctrl),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .count_o     (count),
        .err_cnt_o   (err_cnt)
    );

    // Divide-by-zero and illegal codes return junk the DUT must not forward.
    always_comb begin
        alu_result = 8'hA5;
        case (alu_ctrl)
            4'b0000: alu_result = alu_data0 + alu_data1;
            4'b0001: alu_result = alu_data0 - alu_data1;
            4'b0010: alu_result = alu_data0 * alu_data1;
            4'b0011: alu_result = (alu_data1 == 8'h00) ? 8'h5A : alu_data0 / alu_data1;
            4'b0100: alu_result = (alu_data1 == 8'h00) ? 8'h5A : alu_data0 % alu_data1;
            default: alu_result = 8'hA5;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                         input logic [7:0] exp_res, input logic exp_err, input string tag);
        req_data0 = a;
        req_data1 = b;
        req_ctrl  = c;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_t0_valid"}, 32'(rsp_valid), 0);
        tick();
        check({tag, "_t1_alu_ctrl"}, 32'(alu_ctrl), 32'(c));
        check({tag, "_t1_valid"}, 32'(rsp_valid), 0);
        tick();
        check({tag, "_t2_valid"}, 32'(rsp_valid), 1);
        check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_ctrl"}, 32'(rsp_ctrl), 32'(c));
        tick();
        check({tag, "_ack_valid"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        req_ctrl  = 4'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu_data0", 32'(alu_data0), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 1);

        // Single add with latency checks
        rsp_ready = 1'b1;
        do_op(8'd25, 8'd17, 4'b0000, 8'd42, 1'b0, "add");

        // Wrap and truncation
        do_op(8'hF0, 8'h20, 4'b0000, 8'h10, 1'b0, "add_wrap");
        do_op(8'd5, 8'd9, 4'b0001, 8'hFC, 1'b0, "sub_wrap");
        do_op(8'd20, 8'd20, 4'b0010, 8'h90, 1'b0, "mul_trunc");

        // Errors
        do_op(8'd7, 8'd0, 4'b0011, 8'hFF, 1'b1, "div0");
        do_op(8'd7, 8'd0, 4'b0100, 8'hFF, 1'b1, "mod0");
        do_op(8'd7, 8'd2, 4'b0111, 8'h00, 1'b1, "illegal");
        check("err_cnt_after_errs", 32'(err_cnt), ERRCNT_EXP);

        // Backpressure: five pushes fill path + FIFO
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            req_data0 = 8'(i * 10);
            req_data1 = 8'd1;
            req_ctrl  = 4'b0000;
            req_valid = 1'b1;
            tick();
        end
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(req_ready), 0);
        check("full_busy", 32'(busy), 1);
        check("stall_valid0", 32'(rsp_valid), 1);
        check("stall_result0", 32'(rsp_result), 11);
        req_data0 = 8'd60;
        repeat (2) tick();
        check("stall_count", 32'(count), 4);
        check("stall_valid", 32'(rsp_valid), 1);
        check("stall_result", 32'(rsp_result), 11);
        check("stall_ctrl", 32'(rsp_ctrl), 0);
        check("stall_err", 32'(rsp_err), 0);
        rsp_ready = 1'b1;
        tick();
        check("rel_valid", 32'(rsp_valid), 0);
        check("rel_count", 32'(count), 3);
        check("rel_alu_data0", 32'(alu_data0), 20);
        tick();
        req_valid = 1'b0;
        check("rel_r2_valid", 32'(rsp_valid), 1);
        check("rel_r2_result", 32'(rsp_result), 21);
        check("rel_push6_count", 32'(count), 4);
        for (int k = 3; k <= 6; k++) begin
            tick();
            check("drain_gap", 32'(rsp_valid), 0);
            tick();
            check("drain_valid", 32'(rsp_valid), 1);
            check("drain_result", 32'(rsp_result), 32'(k * 10 + 1));
        end
        tick();
        check("drain_done_count", 32'(count), 0);
        tick();
        check("drain_done_busy", 32'(busy), 0);

        // Simultaneous push and pop with count 2
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_data0 = 8'd100;
            req_data1 = 8'(i);
            req_ctrl  = 4'b0000;
            req_valid = 1'b1;
            tick();
        end
        check("sim_count_pre", 32'(count), 2);
        check("sim_a_valid", 32'(rsp_valid), 1);
        check("sim_a_result", 32'(rsp_result), 101);
        req_data1 = 8'd4;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("sim_count_post", 32'(count), 2);
        check("sim_valid_post", 32'(rsp_valid), 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("sim_valid", 32'(rsp_valid), 1);
            check("sim_result", 32'(rsp_result), 32'(100 + k));
            tick();
            check("sim_gap", 32'(rsp_valid), 0);
        end

        // Reset mid-operation in RESP with count 3
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_data0 = 8'(i);
            req_data1 = 8'd1;
            req_ctrl  = 4'b0000;
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        check("mid_count", 32'(count), 3);
        check("mid_valid", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rel_ready", 32'(req_ready), 1);
        check("mid_rel_busy", 32'(busy), 0);
        rsp_ready = 1'b1;
        do_op(8'd9, 8'd4, 4'b0011, 8'd2, 1'b0, "post_rst_div");
        do_op(8'd9, 8'd4, 4'b0100, 8'd1, 1'b0, "post_rst_mod");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue stage for the 8-bit ALU (add/sub/mul/div/mod).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives one operation at a time onto the ALU operand/control inputs, captures the ALU's combinational result, and presents it on a valid/ready response port.
- Flags division/modulo by zero and illegal control codes.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of count_o.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  FIFO not full.
- req_data0_i  in  8  operand A.
- req_data1_i  in  8  operand B.
- req_ctrl_i  in  4  operation code: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 mod.
- alu_data0_o  out  8  operand A to ALU.
- alu_data1_o  out  8  operand B to ALU.
- alu_ctrl_o  out  4  operation code to ALU.
- alu_result_i  in  8  ALU result, combinational from alu_*_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_result_o  out  8  result.
- rsp_ctrl_o  out  4  operation code echoed with the result.
- rsp_err_o  out  1  error flag.
- busy_o  out  1  FSM not in IDLE, or FIFO not empty.
- count_o  out  CNT_W  FIFO occupancy.
- err_cnt_o  out  8  error count (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_ni low):
  - FIFO emptied; pointers and count_o = 0.
  - FSM = IDLE.
  - alu_data0_o, alu_data1_o, alu_ctrl_o, rsp_result_o, rsp_ctrl_o = 0.
  - rsp_valid_o = 0, rsp_err_o = 0, err_cnt_o = 0.
  - req_ready_o = 1 once reset deasserts.
  - Reset mid-operation discards buffered requests and any pending response.
- Request push: on an edge with req_valid_i && req_ready_o. req_ready_o = (count_o != DEPTH), registered-state based with no combinational path from rsp_ready_i.
- Simultaneous push and pop (non-full): both occur; count_o unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop head into operand registers (alu_*_o) -> EXEC; otherwise stay.
  - EXEC (exactly 1 cycle): ALU settles. At the next edge:
    - rsp_result_o <= alu_result_i.
    - rsp_ctrl_o <= alu_ctrl_o.
    - rsp_err_o <= error condition.
    - rsp_valid_o <= 1.
    - -> RESP.
  - RESP: hold all rsp_* stable while rsp_ready_i = 0. On an edge with rsp_ready_i = 1:
    - rsp_valid_o <= 0.
    - If FIFO non-empty, pop the next entry into the operand registers in the same edge -> EXEC; otherwise -> IDLE.
- Latency: request accepted at edge t0 into an empty idle block -> operands driven after t1 -> rsp_valid_o high after t2.
- Back-to-back throughput: one result per 2 cycles with rsp_ready_i held high.
- alu_*_o hold their last values in IDLE and RESP.
- Error rules, evaluated in EXEC on alu_ctrl_o/alu_data1_o:
  - ctrl 0011 or 0100 with data1 = 0: rsp_err_o = 1, rsp_result_o = 8'hFF (ALU output ignored).
  - ctrl >= 0101: rsp_err_o = 1, rsp_result_o = 8'h00.
  - Otherwise: rsp_err_o = 0, rsp_result_o = alu_result_i (8-bit truncated, wrap-around for add/sub/mul).
- The FIFO preserves order; no request is dropped while req_ready_o = 1.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_ERRCNT_EN.
- Defined: err_cnt_o is an 8-bit counter incremented on each response handshake (rsp_valid_o && rsp_ready_i) whose rsp_err_o = 1. It saturates at 8'hFF and clears only on reset.
- Not defined: no counter logic; err_cnt_o tied to 8'h00.

Test Plan:
- Single add: push (8'd25, 8'd17, 0000) into an idle block; rsp_ready_i = 1 -> rsp_valid_o rises 2 edges after acceptance; rsp_result_o = 42, rsp_err_o = 0, rsp_ctrl_o = 0000.
- Wrap and truncation: (8'hF0, 8'h20, 0000) -> 8'h10; (8'd5, 8'd9, 0001) -> 8'hFC; (8'd20, 8'd20, 0010) -> 8'h90.
- Divide/modulo by zero and illegal code: (8'd7, 8'd0, 0011) -> result 8'hFF, err = 1; (8'd7, 8'd0, 0100) -> 8'hFF, err = 1; (8'd7, 8'd2, 0111) -> 8'h00, err = 1. With the macro defined, err_cnt_o = 3 after all three handshakes.
- Backpressure/full:
  - Hold rsp_ready_i = 0; push 6 requests.
  - Expect 1 request in the operand/response path, then count_o = 4 and req_ready_o = 0.
  - rsp_* stay stable throughout the stall.
  - Release rsp_ready_i -> 5 results out in push order; the 6th push is accepted once not full; results spaced every 2 cycles.
- Simultaneous push/pop: with count_o = 2, push on the same edge a RESP handshake pops -> count_o stays 2; ordering preserved across pointer wrap (issue ≥ 9 ops).
- Reset mid-operation: assert rst_ni low while in RESP with count_o = 3 -> immediately rsp_valid_o = 0, count_o = 0, busy_o = 0, req_ready_o = 1 after release; the next request is processed normally.
